lsu_bytelane_ctrl: RTL and testbench

//  Parametrised load/store unit between the MEM pipeline stage and the data memory.

---
 rtl/lsu_bytelane_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_bytelane_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bytelane_ctrl.sv
// Load/store byte-lane controller: per-byte write enables, load extension, req/ack beat sequencing.
// Define MISALIGN_SPLIT_EN to split lane-crossing accesses into two beats; otherwise they fault.
module lsu_bytelane_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_uns,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic              o_resp_fault
);
  localparam int NB = XLEN/8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t            r_state;
  logic              r_req_ready, r_mem_req, r_mem_we, r_resp_valid, r_resp_fault;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0]     r_mem_be;
  logic [XLEN-1:0]   r_mem_wdata, r_resp_rdata;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [OW-1:0]     r_off;

  logic [OW-1:0]     w_off;
  logic [ADDR_W-1:0] w_addr_al;
  logic              w_legal, w_split, w_fault;
  logic [NB-1:0]     w_be0;
  logic [XLEN-1:0]   w_wd0;
  int                w_offi, w_n;

  assign w_off     = i_req_addr[OW-1:0];
  assign w_addr_al = {i_req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign w_legal   = (i_req_size != 2'd3) || (XLEN == 64);
  assign w_wd0     = i_req_wdata << (8*w_off);

  always_comb begin
    w_offi  = int'(w_off);
    w_n     = 1 << i_req_size;
    w_split = (w_offi + w_n) > NB;
    w_be0   = '0;
    for (int i = 0; i < NB; i++) w_be0[i] = (i >= w_offi) && (i < w_offi + w_n);
  end

`ifdef MISALIGN_SPLIT_EN
  logic [NB-1:0]     w_be1, r_be1;
  logic [XLEN-1:0]   w_wd1, r_wd1, r_rd0;
  logic [ADDR_W-1:0] r_addr1;
  logic              r_split;

  assign w_wd1   = i_req_wdata >> (8*(NB - w_offi));
  assign w_fault = ~w_legal;

  always_comb begin
    w_be1 = '0;
    for (int i = 0; i < NB; i++) w_be1[i] = (i + NB) < (w_offi + w_n);
  end
`else
  assign w_fault = ~w_legal | w_split;
`endif

  // Shift the two-beat window down by the byte offset, keep n bytes, then extend.
  function automatic logic [XLEN-1:0] f_load(input logic [2*XLEN-1:0] cat, input logic [OW-1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] v, mask;
    logic            sgn;
    int              nb;
    v    = XLEN'(cat >> (8*off));
    nb   = 8 << size;
    mask = '0;
    sgn  = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      mask[i] = (i < nb);
      if (i == nb - 1) sgn = v[i];
    end
    return (v & mask) | ((!uns && sgn) ? ~mask : '0);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= '0;
      r_off        <= '0;
`ifdef MISALIGN_SPLIT_EN
      r_be1        <= '0;
      r_wd1        <= '0;
      r_rd0        <= '0;
      r_addr1      <= '0;
      r_split      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_req_ready <= 1'b0;
          r_we        <= i_req_we;
          r_uns       <= i_req_uns;
          r_size      <= i_req_size;
          r_off       <= w_off;
          if (w_fault) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_fault <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_state     <= S_BEAT0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_req_we;
            r_mem_addr  <= w_addr_al;
            r_mem_be    <= w_be0;
            r_mem_wdata <= w_wd0;
`ifdef MISALIGN_SPLIT_EN
            r_split     <= w_split;
            r_be1       <= w_be1;
            r_wd1       <= w_wd1;
            r_addr1     <= w_addr_al + ADDR_W'(NB);
`endif
          end
        end
        S_BEAT0: if (i_mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          if (r_split) begin
            // Second beat follows directly; the ack of beat 0 retires that address.
            r_state     <= S_BEAT1;
            r_rd0       <= i_mem_rdata;
            r_mem_addr  <= r_addr1;
            r_mem_be    <= r_be1;
            r_mem_wdata <= r_wd1;
          end else
`endif
          begin
            r_state      <= S_RESP;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_we ? '0 : f_load({{XLEN{1'b0}}, i_mem_rdata}, r_off, r_size, r_uns);
          end
        end
`ifdef MISALIGN_SPLIT_EN
        S_BEAT1: if (i_mem_ack) begin
          r_state      <= S_RESP;
          r_mem_req    <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_be     <= '0;
          r_mem_wdata  <= '0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_we ? '0 : f_load({i_mem_rdata, r_rd0}, r_off, r_size, r_uns);
        end
`endif
        S_RESP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_be     = r_mem_be;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;
endmodule

// File: tb/tb_lsu_bytelane_ctrl.sv
// Directed vector bench for lsu_bytelane_ctrl (XLEN=32 main instance, XLEN=64 side instance).
module tb_lsu_bytelane_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_ready, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, resp_rdata;
  logic        mem_req, mem_we, mem_ack, resp_valid, resp_fault;
  logic [3:0]  mem_be;

  logic        v64, rdy64, we64, uns64, mreq64, mwe64, ack64, rv64, rf64;
  logic [1:0]  size64;
  logic [31:0] addr64, maddr64;
  logic [63:0] wdata64, mwd64, mrd64, rrd64;
  logic [7:0]  mbe64;

  lsu_bytelane_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_uns(req_uns), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_fault(resp_fault));

  lsu_bytelane_ctrl #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v64), .o_req_ready(rdy64),
    .i_req_we(we64), .i_req_size(size64), .i_req_uns(uns64), .i_req_addr(addr64),
    .i_req_wdata(wdata64), .o_mem_req(mreq64), .o_mem_we(mwe64), .o_mem_addr(maddr64),
    .o_mem_be(mbe64), .o_mem_wdata(mwd64), .i_mem_ack(ack64), .i_mem_rdata(mrd64),
    .o_resp_valid(rv64), .o_resp_rdata(rrd64), .o_resp_fault(rf64));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rd0, rd1;
    int          nb;            // memory beats; 0 means the access faults
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1, rdata;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
      input logic [31:0] addr, wdata, rd0, rd1, input int nb, input logic [31:0] a0,
      input logic [3:0] be0, input logic [31:0] wd0, a1, input logic [3:0] be1,
      input logic [31:0] wd1, rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd0 = rd0;
    v.rd1 = rd1; v.nb = nb; v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1;
    v.wd1 = wd1; v.rdata = rdata;
    return v;
  endfunction

  // Issue one access; memory acks each beat after dly wait cycles.
  task automatic run(input vec_t v, input int dly, input bit noise);
    req_we = v.we; req_size = v.size; req_uns = v.uns; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    chk("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.nb == 0) chk("fault_no_mem_req", mem_req, 0);
    for (int b = 0; b < v.nb; b++) begin
      for (int d = 0; d <= dly; d++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, v.we);
        chk("mem_addr", mem_addr, (b == 0) ? v.a0 : v.a1);
        chk("mem_be", mem_be, (b == 0) ? v.be0 : v.be1);
        chk("mem_wdata", mem_wdata, (b == 0) ? v.wd0 : v.wd1);
        chk("ready_busy", req_ready, 0);
        chk("resp_early", resp_valid, 0);
        if (d == dly) begin
          mem_ack = 1'b1; mem_rdata = (b == 0) ? v.rd0 : v.rd1; req_valid = 1'b0;
        end else if (noise) begin
          req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0999;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_DEAD;
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_fault", resp_fault, (v.nb == 0));
    chk("resp_rdata", resp_rdata, v.rdata);
    chk("resp_mem_req", mem_req, 0);
    chk("resp_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("resp_pulse", resp_valid, 0);
    chk("ready_again", req_ready, 1);
  endtask

  vec_t tv[12];

  initial begin
    tv[0]  = mk(0, 0, 0, 32'h103, 32'h1234_5678, 32'h80FF_0000, 0, 1, 32'h100, 4'b1000, 32'h7800_0000, 0, 0, 0, 32'hFFFF_FF80);
    tv[1]  = mk(1, 1, 0, 32'h202, 32'h0000_ABCD, 0, 0, 1, 32'h200, 4'b1100, 32'hABCD_0000, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 32'h101, 0, 32'h0000_8000, 0, 1, 32'h100, 4'b0010, 0, 0, 0, 0, 32'h0000_0080);
    tv[4]  = mk(0, 1, 0, 32'h100, 0, 32'h1234_8001, 0, 1, 32'h100, 4'b0011, 0, 0, 0, 0, 32'hFFFF_8001);
    tv[5]  = mk(0, 1, 1, 32'h102, 0, 32'h9ABC_0000, 0, 1, 32'h100, 4'b1100, 0, 0, 0, 0, 32'h0000_9ABC);
    tv[6]  = mk(1, 2, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, 1, 32'h40, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tv[7]  = mk(1, 0, 0, 32'h7, 32'h0000_00AA, 0, 0, 1, 32'h4, 4'b1000, 32'hAA00_0000, 0, 0, 0, 0);
    tv[8]  = mk(0, 3, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[9]  = mk(0, 2, 0, 32'h20, 0, 32'h8000_0001, 0, 1, 32'h20, 4'b1111, 0, 0, 0, 0, 32'h8000_0001);
`ifdef MISALIGN_SPLIT_EN
    tv[2]  = mk(0, 2, 0, 32'h301, 0, 32'h4433_2211, 32'h0000_0055, 2, 32'h300, 4'b1110, 0, 32'h304, 4'b0001, 0, 32'h5544_3322);
    tv[10] = mk(1, 1, 0, 32'h3, 32'h0000_1122, 0, 0, 2, 32'h0, 4'b1000, 32'h2200_0000, 32'h4, 4'b0001, 32'h0000_0011, 0);
    tv[11] = mk(0, 2, 0, 32'hFFFF_FFFE, 0, 32'hBBAA_0000, 32'h0000_DDCC, 2, 32'hFFFF_FFFC, 4'b1100, 0, 32'h0, 4'b0011, 0, 32'hDDCC_BBAA);
`else
    tv[2]  = mk(0, 2, 0, 32'h301, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(1, 1, 0, 32'h3, 32'h0000_1122, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[11] = mk(0, 2, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    v64 = 1'b0; we64 = 1'b0; size64 = '0; uns64 = 1'b0; addr64 = '0; wdata64 = '0;
    ack64 = 1'b0; mrd64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray ack while idle has no effect.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_resp", resp_valid, 0);
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_ready", req_ready, 1);

    for (int i = 0; i < 12; i++) run(tv[i], 0, 1'b0);

    // Slow memory with a competing request held during the stall.
    run(mk(0, 1, 1, 32'h10, 0, 32'h0000_F00D, 0, 1, 32'h10, 4'b0011, 0, 0, 0, 0, 32'h0000_F00D), 3, 1'b1);

    // Async reset while a store beat is outstanding.
    req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0; req_wdata = 32'h1122_3344;
`ifdef MISALIGN_SPLIT_EN
    req_addr = 32'h2;
`else
    req_addr = 32'h8;
`endif
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rst_beat1_addr", mem_addr, 32'h4);
`endif
    chk("rst_pre_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_resp", resp_valid, 0);
      chk("rst_idle_req", mem_req, 0);
    end

    // XLEN=64: aligned dword store, then lw in the upper half with sign extension.
    we64 = 1'b1; size64 = 2'd3; addr64 = 32'h1000; wdata64 = 64'h0123_4567_89AB_CDEF; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    chk("x64_sd_req", mreq64, 1);
    chk("x64_sd_be", mbe64, 8'hFF);
    chk("x64_sd_addr", maddr64, 32'h1000);
    chk("x64_sd_wdata", mwd64, 64'h0123_4567_89AB_CDEF);
    ack64 = 1'b1;
    @(posedge clk); #1;
    ack64 = 1'b0;
    chk("x64_sd_resp", rv64, 1);
    chk("x64_sd_fault", rf64, 0);
    @(posedge clk); #1;
    we64 = 1'b0; size64 = 2'd2; uns64 = 1'b0; addr64 = 32'h1004; wdata64 = '0; v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    chk("x64_lw_be", mbe64, 8'hF0);
    chk("x64_lw_addr", maddr64, 32'h1000);
    ack64 = 1'b1; mrd64 = 64'h8000_0000_1111_1111;
    @(posedge clk); #1;
    ack64 = 1'b0;
    chk("x64_lw_resp", rv64, 1);
    chk("x64_lw_rdata", rrd64, 64'hFFFF_FFFF_8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
